// File: rtl/fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flex
// Description : Single-clock synchronous FIFO of arbitrary depth.
//               The pointers wrap explicitly, so FIFO_DEPTH does not have to
//               be a power of two. The FIFO reports its occupancy and has
//               programmable almost-full and almost-empty flags. Overflow and
//               underflow are sticky error flags. The FIFO has a synchronous
//               flush. The read side works in one of two modes:
//               registered read, or first-word-fall-through.
//
// Ports       : clk          - clock, rising edge
//               rst_n        - asynchronous active-low reset
//               clr          - synchronous flush, active-high, highest priority
//               wr_en, din   - write request and write data
//               rd_en        - read request (FWFT=1: pop of the head word)
//               dout         - read data
//               dout_valid   - dout holds valid data
//               full, empty  - level == FIFO_DEPTH / level == 0
//               almost_full  - level >= AF_THRESH
//               almost_empty - level <= AE_THRESH
//               level        - current occupancy
//               overflow     - sticky: a write was rejected
//               underflow    - sticky: a read was rejected
//
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 4,
    parameter int FWFT       = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            wr_en,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            dout_valid,
    output logic                            full,
    output logic                            empty,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
    output logic                            overflow,
    output logic                            underflow
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_LVL_W-1:0] c_LVL_MAX  = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_LVL_W-1:0] c_AF_LVL   = c_LVL_W'(AF_THRESH);
    localparam logic [c_LVL_W-1:0] c_AE_LVL   = c_LVL_W'(AE_THRESH);
    localparam logic [c_LVL_W-1:0] c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (FIFO_DEPTH < 2) begin : g_chk_depth
        $error("fifo_flex: FIFO_DEPTH must be >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > FIFO_DEPTH)) begin : g_chk_af
        $error("fifo_flex: AF_THRESH must be in 1..FIFO_DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > FIFO_DEPTH - 1)) begin : g_chk_ae
        $error("fifo_flex: AE_THRESH must be in 0..FIFO_DEPTH-1");
    end
    if (DATA_WIDTH < 1) begin : g_chk_width
        $error("fifo_flex: DATA_WIDTH must be >= 1");
    end

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_LVL_W-1:0]    r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wa;
    logic                  w_ra;
    logic [c_PTR_W-1:0]    w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]    w_rd_ptr_nxt;
    logic [c_LVL_W-1:0]    w_level_nxt;

    // Status is decoded straight from the registered level. The flags then
    // follow the level on the same edge with no extra register stage.
    assign w_full       = (r_level == c_LVL_MAX);
    assign w_empty      = (r_level == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= c_AF_LVL);
    assign almost_empty = (r_level <= c_AE_LVL);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A flush cancels every access in its cycle. So the accepted-access
    // terms are gated with clr. Memory, pointers and dout then all see one
    // consistent view.
    assign w_wa = wr_en && !w_full  && !clr;
    assign w_ra = rd_en && !w_empty && !clr;

    // Explicit wrap at FIFO_DEPTH-1. This keeps the arithmetic correct for
    // depths that are not a power of two.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : (r_wr_ptr + c_PTR_ONE);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : (r_rd_ptr + c_PTR_ONE);

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wa, w_ra})
            2'b10:   w_level_nxt = r_level + c_LVL_ONE;
            2'b01:   w_level_nxt = r_level - c_LVL_ONE;
            default: w_level_nxt = r_level;   // both or neither: no change
        endcase
    end

    // ------------------------------------------------------------------------
    // Memory array. There is no reset, so it maps onto plain RAM.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wa) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, level and sticky error flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wa) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_ra) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_level <= w_level_nxt;
            // A write to a full FIFO is rejected even if a read frees a
            // slot on the same edge. The write is still counted as overflow.
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------------
    if (FWFT == 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] r_dout;
        logic                  r_dout_valid;

        // dout keeps its last value between reads and across a flush. Only
        // dout_valid marks the single cycle in which the word is new.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_dout       <= '0;
                r_dout_valid <= 1'b0;
            end else begin
                r_dout_valid <= w_ra;
                if (w_ra) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end
        end

        assign dout       = r_dout;
        assign dout_valid = r_dout_valid;
    end else begin : g_fwft
        // The head word is presented combinationally. While the FIFO is
        // empty the output is forced to zero. This keeps stale or
        // uninitialised RAM contents off dout, most visibly right after
        // reset.
        assign dout       = w_empty ? '0 : r_mem[r_rd_ptr];
        assign dout_valid = !w_empty;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_flex.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_flex
// Description : Directed testbench for fifo_flex.
//               Instance A: depth 5, registered read, AF=3, AE=1.
//               Instance B: depth 4, first-word-fall-through, AF=3, AE=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_flex;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Instance A signals
    logic       clr_a = 1'b0, wr_a = 1'b0, rd_a = 1'b0;
    logic [7:0] din_a = '0;
    logic [7:0] dout_a;
    logic       vld_a, full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
    logic [2:0] lvl_a;

    // Instance B signals
    logic       clr_b = 1'b0, wr_b = 1'b0, rd_b = 1'b0;
    logic [7:0] din_b = '0;
    logic [7:0] dout_b;
    logic       vld_b, full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
    logic [2:0] lvl_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_flex #(
        .DATA_WIDTH(8), .FIFO_DEPTH(5), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .clr(clr_a), .wr_en(wr_a), .din(din_a),
        .rd_en(rd_a), .dout(dout_a), .dout_valid(vld_a), .full(full_a),
        .empty(empty_a), .almost_full(af_a), .almost_empty(ae_a),
        .level(lvl_a), .overflow(ovf_a), .underflow(udf_a)
    );

    fifo_flex #(
        .DATA_WIDTH(8), .FIFO_DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .clr(clr_b), .wr_en(wr_b), .din(din_b),
        .rd_en(rd_b), .dout(dout_b), .dout_valid(vld_b), .full(full_b),
        .empty(empty_b), .almost_full(af_b), .almost_empty(ae_b),
        .level(lvl_b), .overflow(ovf_b), .underflow(udf_b)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic       clr;
        logic [7:0] din;
        int         lvl;
        logic [7:0] dout;
        logic       valid;
        logic       ovf;
        logic       udf;
    } vec_t;

    localparam int c_NVEC = 24;
    vec_t vecs [c_NVEC];

    function automatic vec_t mk(logic wr, logic rd, logic cl, logic [7:0] din,
                                int lvl, logic [7:0] dout, logic valid,
                                logic ovf, logic udf);
        vec_t v;
        v.wr = wr; v.rd = rd; v.clr = cl; v.din = din; v.lvl = lvl;
        v.dout = dout; v.valid = valid; v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Flags of A as defined by the level: depth 5, AF=3, AE=1
    task automatic chk_a_state(input string tag, input int lvl, input logic [7:0] dout,
                               input logic valid, input logic ovf, input logic udf);
        chk({tag, " level"},        32'(lvl_a),   32'(lvl));
        chk({tag, " full"},         32'(full_a),  32'(lvl == 5));
        chk({tag, " empty"},        32'(empty_a), 32'(lvl == 0));
        chk({tag, " almost_full"},  32'(af_a),    32'(lvl >= 3));
        chk({tag, " almost_empty"}, 32'(ae_a),    32'(lvl <= 1));
        chk({tag, " dout"},         32'(dout_a),  32'(dout));
        chk({tag, " dout_valid"},   32'(vld_a),   32'(valid));
        chk({tag, " overflow"},     32'(ovf_a),   32'(ovf));
        chk({tag, " underflow"},    32'(udf_a),   32'(udf));
    endtask

    task automatic step_a(input logic wr, input logic rd, input logic cl, input logic [7:0] d);
        wr_a = wr; rd_a = rd; clr_a = cl; din_a = d;
        @(posedge clk);
        #1;
        wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
    endtask

    task automatic step_b(input logic wr, input logic rd, input logic [7:0] d);
        wr_b = wr; rd_b = rd; din_b = d;
        @(posedge clk);
        #1;
        wr_b = 1'b0; rd_b = 1'b0;
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] exp_d;

        //             wr rd clr din    lvl dout   vld ovf udf
        vecs[0]  = mk(1, 0, 0, 8'h11, 1, 8'h00, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 8'h12, 2, 8'h00, 0, 0, 0);
        vecs[2]  = mk(1, 0, 0, 8'h13, 3, 8'h00, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 8'h14, 4, 8'h00, 0, 0, 0);
        vecs[4]  = mk(1, 0, 0, 8'h15, 5, 8'h00, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 8'h16, 5, 8'h00, 0, 1, 0);  // rejected write
        vecs[6]  = mk(0, 1, 0, 8'h00, 4, 8'h11, 1, 1, 0);
        vecs[7]  = mk(0, 1, 0, 8'h00, 3, 8'h12, 1, 1, 0);
        vecs[8]  = mk(0, 1, 0, 8'h00, 2, 8'h13, 1, 1, 0);
        vecs[9]  = mk(0, 1, 0, 8'h00, 1, 8'h14, 1, 1, 0);
        vecs[10] = mk(0, 1, 0, 8'h00, 0, 8'h15, 1, 1, 0);
        vecs[11] = mk(0, 0, 0, 8'h00, 0, 8'h15, 0, 1, 0);  // dout holds
        vecs[12] = mk(1, 1, 0, 8'h21, 1, 8'h15, 0, 1, 1);  // empty: wr ok, rd rejected
        vecs[13] = mk(1, 0, 0, 8'h22, 2, 8'h15, 0, 1, 1);
        vecs[14] = mk(1, 0, 0, 8'h23, 3, 8'h15, 0, 1, 1);
        vecs[15] = mk(1, 1, 1, 8'h99, 0, 8'h15, 0, 0, 0);  // flush beats wr/rd
        vecs[16] = mk(1, 0, 0, 8'h31, 1, 8'h15, 0, 0, 0);
        vecs[17] = mk(1, 0, 0, 8'h32, 2, 8'h15, 0, 0, 0);
        vecs[18] = mk(1, 0, 0, 8'h33, 3, 8'h15, 0, 0, 0);
        vecs[19] = mk(1, 0, 0, 8'h34, 4, 8'h15, 0, 0, 0);
        vecs[20] = mk(1, 0, 0, 8'h35, 5, 8'h15, 0, 0, 0);
        vecs[21] = mk(1, 1, 0, 8'h36, 4, 8'h31, 1, 1, 0);  // full: rd ok, wr rejected
        vecs[22] = mk(0, 1, 0, 8'h00, 3, 8'h32, 1, 1, 0);
        vecs[23] = mk(0, 0, 0, 8'h00, 3, 8'h32, 0, 1, 0);

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk_a_state("reset", 0, 8'h00, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_a_state("post-reset", 0, 8'h00, 0, 0, 0);

        // Table-driven sequence on instance A
        for (int i = 0; i < c_NVEC; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step_a(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            chk_a_state(tag, vecs[i].lvl, vecs[i].dout, vecs[i].valid,
                        vecs[i].ovf, vecs[i].udf);
        end

        // Pointer wrap: the FIFO holds 33,34,35. Drop to level 2, then do
        // 12 simultaneous write/read pairs.
        step_a(0, 1, 0, 8'h00);
        chk("wrap pre dout", 32'(dout_a), 32'h33);
        chk("wrap pre level", 32'(lvl_a), 32'd2);
        q.push_back(8'h34);
        q.push_back(8'h35);
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            d = 8'h40 + 8'(i);
            q.push_back(d);
            exp_d = q.pop_front();
            step_a(1, 1, 0, d);
            chk($sformatf("wrap%0d dout", i),  32'(dout_a), 32'(exp_d));
            chk($sformatf("wrap%0d valid", i), 32'(vld_a),  32'd1);
            chk($sformatf("wrap%0d level", i), 32'(lvl_a),  32'd2);
        end
        // Drain the two remaining words. Order must be preserved.
        for (int i = 0; i < 2; i++) begin
            exp_d = q.pop_front();
            step_a(0, 1, 0, 8'h00);
            chk($sformatf("wrap drain%0d dout", i), 32'(dout_a), 32'(exp_d));
        end
        chk("wrap drained empty", 32'(empty_a), 32'd1);

        // Flush at level 3 with overflow set
        step_a(1, 0, 0, 8'h51);
        step_a(1, 0, 0, 8'h52);
        step_a(1, 0, 0, 8'h53);
        chk("pre-clr level", 32'(lvl_a), 32'd3);
        chk("pre-clr overflow", 32'(ovf_a), 32'd1);
        step_a(1, 0, 1, 8'h54);
        chk_a_state("clr", 0, 8'h4b, 0, 0, 0);

        // Asynchronous reset in the middle of a burst
        step_a(1, 0, 0, 8'h61);
        step_a(1, 1, 0, 8'h62);
        wr_a = 1'b1; din_a = 8'h63;
        @(posedge clk);
        #3;
        chk("burst level", 32'(lvl_a), 32'd2);
        chk("burst dout", 32'(dout_a), 32'h61);
        rst_n = 1'b0;
        #1;
        chk_a_state("async-rst", 0, 8'h00, 0, 0, 0);
        wr_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // FWFT instance B
        @(posedge clk);
        #1;
        chk("B reset valid", 32'(vld_b), 32'd0);
        chk("B reset empty", 32'(empty_b), 32'd1);
        chk("B reset dout", 32'(dout_b), 32'h00);
        step_b(1, 0, 8'hA5);
        chk("B wr dout", 32'(dout_b), 32'hA5);
        chk("B wr valid", 32'(vld_b), 32'd1);
        chk("B wr level", 32'(lvl_b), 32'd1);
        step_b(1, 1, 8'h3C);
        chk("B pop+wr dout", 32'(dout_b), 32'h3C);
        chk("B pop+wr valid", 32'(vld_b), 32'd1);
        chk("B pop+wr level", 32'(lvl_b), 32'd1);
        step_b(1, 0, 8'h01);
        chk("B wr2 dout", 32'(dout_b), 32'h3C);
        chk("B wr2 level", 32'(lvl_b), 32'd2);
        step_b(0, 1, 8'h00);
        chk("B pop dout", 32'(dout_b), 32'h01);
        chk("B pop level", 32'(lvl_b), 32'd1);
        step_b(0, 1, 8'h00);
        chk("B pop-last valid", 32'(vld_b), 32'd0);
        chk("B pop-last empty", 32'(empty_b), 32'd1);
        chk("B pop-last underflow", 32'(udf_b), 32'd0);
        step_b(0, 1, 8'h00);
        chk("B rd-empty underflow", 32'(udf_b), 32'd1);
        chk("B rd-empty level", 32'(lvl_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
Single-clock synchronous FIFO that supersedes the basic fifo primitive and is the building block for the next multi-FIFO wrappers.
- Depth may be any integer (not only a power of two), with explicit pointer wrap.
- Adds a correct simultaneous read/write count, occupancy output, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and a selectable read mode: registered-read or first-word-fall-through (FWFT).

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
FIFO_DEPTH, 16, number of entries; any integer >=2
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH; legal range 1..FIFO_DEPTH
AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH; legal range 0..FIFO_DEPTH-1
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; asynchronous, active-low
clr  input  1  synchronous flush, active-high
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request (FWFT=1: pop/acknowledge of head word)
dout  output  DATA_WIDTH  read data
dout_valid  output  1  dout holds valid data (meaning depends on FWFT)
full  output  1  level == FIFO_DEPTH
empty  output  1  level == 0
almost_full  output  1  level >= AF_THRESH
almost_empty  output  1  level <= AE_THRESH
level  output  $clog2(FIFO_DEPTH+1)  current occupancy
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers and level go to 0; overflow, underflow, dout and dout_valid go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not cleared and are unreadable after reset.
  - Reset asserted mid-operation discards all queued data.
- Pointers run over 0..FIFO_DEPTH-1. Next value is 0 when the pointer equals FIFO_DEPTH-1, else pointer+1. No modulo-2^n arithmetic.
- Write accepted (wa) = wr_en && !full. Read accepted (ra) = rd_en && !empty. Both use flags registered before the edge.
  - A write to a full FIFO is rejected even if a read occurs in the same cycle.
- Level update per edge:
  - +1 on wa only.
  - -1 on ra only.
  - Unchanged on wa&&ra; both pointers still advance.
  - Unchanged when neither is accepted.
- All flags and level are derived combinationally from the registered level. They reflect post-edge state with no extra lag.
- overflow is set on any edge with wr_en && full. underflow is set on any edge with rd_en && empty.
  - Both hold until clr or reset. A rejected access has no other effect.
- clr=1 at an edge:
  - Pointers and level go to 0; overflow and underflow clear; dout_valid goes to 0. dout holds its value.
  - wr_en and rd_en in the same cycle are ignored and do not set the sticky flags.
  - clr has priority over all other operations.
- FWFT=0:
  - On ra, dout is loaded at the edge with mem[rd_ptr] and dout_valid=1 for exactly the following cycle.
  - Otherwise dout holds its value and dout_valid=0.
  - Read latency is 1 cycle.
- FWFT=1:
  - dout = mem[rd_ptr] combinationally and dout_valid = !empty.
  - A word written into an empty FIFO appears on dout in the cycle after the write edge.
  - rd_en while dout_valid pops the head word. The next word, if any, is presented in the cycle after the pop edge.
- Simultaneous wa and ra when level==1 (FWFT=1): the head word is popped and the new word becomes head. Level stays 1 and dout_valid stays 1.
- Illegal parameters (FIFO_DEPTH<2, or either threshold out of range) cause an elaboration-time error.

Test Plan:
- FIFO_DEPTH=5, FWFT=0: write 0x11..0x15 -> full=1 and level=5 after the 5th edge; 6th write sets overflow=1 and level stays 5. Read 5 words -> dout=0x11..0x15 in order, each one cycle after its rd_en, with dout_valid pulses.
- FIFO_DEPTH=5: run 12 write/read pairs through a half-full FIFO -> pointers wrap 4->0 repeatedly, data order preserved, level constant at 2 throughout the simultaneous phase.
- Full FIFO, wr_en=rd_en=1 -> read accepted, write rejected, level goes 5->4, overflow=1. Empty FIFO, wr_en=rd_en=1 -> write accepted, read rejected, level=1, underflow=1.
- AF_THRESH=3, AE_THRESH=1: fill 0->5 then drain -> almost_empty=1 at levels 0-1, almost_full=1 at levels 3-5, both toggle on the exact edge the level crosses.
- FWFT=1: write 0xA5 into empty FIFO -> next cycle dout=0xA5, dout_valid=1. Pop with a simultaneous write of 0x3C -> level=1, dout=0x3C.
- At level 3 with overflow set, pulse clr with wr_en=1 -> level=0, empty=1, overflow=0. Assert rst_n=0 asynchronously mid-burst -> all outputs return to reset values without waiting for a clock edge.
